instruction_loader: RTL and testbench

Upstream feeder for the instruction RAM write port. Accepts a byte stream (valid/ready) and packs bytes MSB-first into 32-bit instruction words. Writes each word to consecutive instruction-RAM addresses from a programmable base, then checks a trailing 8-bit checksum byte. Sits between the external byte source (UART/debug receiver) and the instruction RAM's write inputs (address, data, write flag).

---
 rtl/loader_pkg.sv | 24 ++
 rtl/loader_word_packer.sv | 54 +++++
 rtl/instruction_loader.sv | 188 ++++++++++++++++++
 tb/tb_instruction_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader.
//   loader_state_e : FSM state encoding (also exported on the debug port)
//   BYTES_PER_WORD : bytes per instruction word at the default 32-bit width
//   CHECKSUM_W     : width of the running modulo-256 checksum
//   bytes_per_word : bytes per word for an arbitrary word width
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECEIVE = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    FINISH  = 3'd4
  } loader_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;
  localparam int CHECKSUM_W         = 8;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Packs accepted bytes MSB-first into one instruction word.
//   clock, reset     : system clock, synchronous active-high reset
//   clear_i          : drop any partial word and restart at byte 0
//   shift_i          : a byte is accepted this cycle
//   byte_i           : the accepted byte
//   word_next_o      : the word including byte_i (valid while shift_i is high)
//   complete_o       : byte_i is the last byte of the current word
module loader_word_packer
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  shift_i,
  input  logic [7:0]            byte_i,
  output logic [DATA_WIDTH-1:0] word_next_o,
  output logic                  complete_o
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IW-1:0]         idx_q, idx_d;

  // Shift form works for any multiple of 8, including a single-byte word.
  assign word_next_o = (word_q << 8) | DATA_WIDTH'(byte_i);
  assign complete_o  = shift_i && (idx_q == IW'(BPW - 1));

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (shift_i) begin
      word_d = word_next_o;
      idx_d  = complete_o ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Byte-stream to instruction-RAM loader. Packs bytes into words, writes them
// to consecutive addresses from a latched base, then verifies a trailing
// modulo-256 checksum byte. An idle timeout aborts a stalled load.
//   clock, reset                 : system clock, synchronous active-high reset
//   start, base_address,
//   word_count                   : load request (sampled only in IDLE)
//   byte_in, byte_valid,
//   byte_ready                   : byte stream handshake
//   address, i_ram_input,
//   flag_write_i_ram             : registered RAM write port
//   busy, done, error            : status
//   state_dbg                    : current FSM state
//
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready.
// byte_ready depends only on the state (high in RECEIVE and CHECK), never on
// byte_valid, so the source may hold byte_valid high for as long as it likes.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic [ADDR_WIDTH-1:0] word_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] i_ram_input,
  output logic                  flag_write_i_ram,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output loader_state_e         state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [CHECKSUM_W-1:0] csum_q, csum_d;
  logic [TW-1:0]         idle_q, idle_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic                  timeout_hit;
  logic [ADDR_WIDTH-1:0] word_idx_inc;
  logic                  pk_clear;
  logic                  pk_shift;
  logic [DATA_WIDTH-1:0] pk_word_next;
  logic                  pk_complete;

  assign byte_ready       = (state_q == RECEIVE) || (state_q == CHECK);
  assign busy             = (state_q == RECEIVE) || (state_q == WRITE) || (state_q == CHECK);
  assign address          = addr_q;
  assign i_ram_input      = data_q;
  assign flag_write_i_ram = wr_q;
  assign done             = done_q;
  assign error            = error_q;
  assign state_dbg        = state_q;

  assign accept       = byte_valid && byte_ready;
  // idle_q counts idle cycles already spent; this is the TIMEOUT_CYCLES-th.
  assign timeout_hit  = !accept && (idle_q == TW'(TIMEOUT_CYCLES - 1));
  assign word_idx_inc = word_idx_q + 1'b1;
  assign pk_shift     = (state_q == RECEIVE) && accept;

  loader_word_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (pk_clear),
    .shift_i     (pk_shift),
    .byte_i      (byte_in),
    .word_next_o (pk_word_next),
    .complete_o  (pk_complete)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    csum_d     = csum_q;
    idle_d     = idle_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = 1'b0;
    done_d     = 1'b0;
    error_d    = error_q;
    pk_clear   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d     = base_address;
          count_d    = word_count;
          word_idx_d = '0;
          csum_d     = '0;
          idle_d     = '0;
          error_d    = 1'b0;
          pk_clear   = 1'b1;
          state_d    = (word_count == '0) ? FINISH : RECEIVE;
        end
      end
      RECEIVE: begin
        if (accept) begin
          csum_d = csum_q + byte_in;
          idle_d = '0;
          // Load the write registers on the last byte so the strobe, address
          // and data all appear together during the WRITE cycle.
          if (pk_complete) begin
            wr_d    = 1'b1;
            addr_d  = base_q + word_idx_q;
            data_d  = pk_word_next;
            state_d = WRITE;
          end
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = FINISH;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      WRITE: begin
        word_idx_d = word_idx_inc;
        state_d    = (word_idx_inc == count_q) ? CHECK : RECEIVE;
      end
      CHECK: begin
        if (accept) begin
          idle_d = '0;
          if (byte_in != csum_q) error_d = 1'b1;
          state_d = FINISH;
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = FINISH;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      csum_q     <= '0;
      idle_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      csum_q     <= csum_d;
      idle_q     <= idle_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;
  import loader_pkg::*;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int TO  = 16;
  localparam int BPW = DW / 8;

  logic          clock;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_address;
  logic [AW-1:0] word_count;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [AW-1:0] address;
  logic [DW-1:0] i_ram_input;
  logic          flag_write_i_ram;
  logic          busy;
  logic          done;
  logic          error;
  loader_state_e state_dbg;

  instruction_loader #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .base_address     (base_address),
    .word_count       (word_count),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .address          (address),
    .i_ram_input      (i_ram_input),
    .flag_write_i_ram (flag_write_i_ram),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .state_dbg        (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [AW+DW-1:0] exp_q[$];       // expected {address, data} per write
  logic             exp_done_q[$];  // expected error level at each done pulse
  logic [7:0]       stream[$];      // payload bytes for the current load

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every write strobe and done pulse against the queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (flag_write_i_ram) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h required no write", address, i_ram_input);
        end else begin
          check("write_addr_data", {address, i_ram_input}, exp_q.pop_front());
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 required no done");
        end else begin
          check("done_error", error, exp_done_q.pop_front());
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] model_word(input int w);
    logic [DW-1:0] v = '0;
    for (int b = 0; b < BPW; b++)
      v = v * 256 + DW'(stream[w * BPW + b]);
    return v;
  endfunction

  function automatic logic [7:0] model_sum(input int nbytes);
    int s = 0;
    for (int k = 0; k < nbytes; k++) s += stream[k];
    return 8'(s % 256);
  endfunction

  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base, input int w);
    return AW'((int'(base) + w) % (1 << AW));
  endfunction

  // ---------------- drivers ----------------
  task automatic fill_random(input int nbytes);
    stream.delete();
    for (int k = 0; k < nbytes; k++) stream.push_back(8'($urandom_range(0, 255)));
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int n = 0;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_in    = b;
    while (!byte_ready && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (byte_ready) begin
      @(negedge clock);
      ok = 1'b1;
    end
    byte_valid = 1'b0;
    byte_in    = 8'($urandom_range(0, 255));
  endtask

  task automatic issue_start(input logic [AW-1:0] base, input logic [AW-1:0] cnt);
    base_address = base;
    word_count   = cnt;
    start        = 1'b1;
    @(negedge clock);
    start        = 1'b0;
    base_address = AW'($urandom_range(0, 1023));
    word_count   = AW'($urandom_range(0, 1023));
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1'b1);
  endtask

  // stall_at < 0: full load followed by chk. Otherwise the source stops
  // after stall_at bytes and the load must time out.
  task automatic run_load(input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                          input logic [7:0] chk, input int stall_at);
    int  nbytes;
    int  full_words;
    bit  ok;
    logic exp_err;
    nbytes     = int'(cnt) * BPW;
    full_words = (stall_at >= 0) ? stall_at / BPW : int'(cnt);
    exp_err    = (stall_at >= 0) ? 1'b1 : (chk != model_sum(nbytes));
    for (int w = 0; w < full_words; w++)
      exp_q.push_back({model_addr(base, w), model_word(w)});
    exp_done_q.push_back(exp_err);

    // Bytes offered while idle must not be taken.
    byte_valid = 1'b1;
    byte_in    = 8'($urandom_range(0, 255));
    repeat (2) begin
      @(negedge clock);
      check("ready_low_idle", byte_ready, 1'b0);
    end
    byte_valid = 1'b0;

    issue_start(base, cnt);
    check("error_clear_on_start", error, 1'b0);

    if (cnt == '0) begin
      check("zero_no_ready", byte_ready, 1'b0);
      check("zero_done_early", done, 1'b0);
      @(negedge clock);
      check("zero_no_ready", byte_ready, 1'b0);
      check("zero_done_latency", done, 1'b1);
    end else begin
      for (int k = 0; k < nbytes; k++) begin
        if (k == stall_at) break;
        repeat ($urandom_range(0, 2)) @(negedge clock);
        send_byte(stream[k], ok);
        check("byte_accepted", ok, 1'b1);
      end
      if (stall_at < 0) begin
        repeat ($urandom_range(0, 2)) @(negedge clock);
        send_byte(chk, ok);
        check("checksum_accepted", ok, 1'b1);
      end
      wait_done(TO + 40);
    end
    @(negedge clock);
    check("busy_after_done", busy, 1'b0);
    check("error_after_done", error, exp_err);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    logic [7:0] s;
    logic [AW-1:0] rb;
    logic [AW-1:0] rc;
    reset        = 1'b1;
    start        = 1'b0;
    base_address = '0;
    word_count   = '0;
    byte_in      = '0;
    byte_valid   = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_outputs",
          {byte_ready, address, i_ram_input, flag_write_i_ram, busy, done, error},
          '0);

    // Known stream, correct checksum.
    stream = '{8'h80, 8'h40, 8'h00, 8'h00, 8'h80, 8'h60, 8'h00, 8'h00};
    run_load(10'd0, 10'd2, 8'hA0, -1);

    // Same stream, wrong checksum: both words still land, error at done.
    stream = '{8'h80, 8'h40, 8'h00, 8'h00, 8'h80, 8'h60, 8'h00, 8'h00};
    run_load(10'd0, 10'd2, 8'hA1, -1);

    // Source stalls after two bytes.
    fill_random(8);
    run_load(10'd5, 10'd2, 8'h00, 2);

    // Stall after one complete word: only that word is written.
    fill_random(8);
    run_load(10'd100, 10'd2, 8'h00, 5);

    // Address wrap.
    fill_random(8);
    run_load(10'd1023, 10'd2, model_sum(8), -1);

    // Zero-length load.
    stream.delete();
    run_load(10'd7, 10'd0, 8'h00, -1);

    // Randomised loads.
    for (int t = 0; t < 8; t++) begin
      rb = AW'($urandom_range(0, 1023));
      rc = AW'($urandom_range(1, 4));
      fill_random(int'(rc) * BPW);
      s  = model_sum(int'(rc) * BPW);
      if ($urandom_range(0, 1) == 1) s = s + 8'($urandom_range(1, 255));
      run_load(rb, rc, s, -1);
    end

    // Reset in the middle of the second word.
    fill_random(8);
    exp_q.push_back({model_addr(10'd300, 0), model_word(0)});
    issue_start(10'd300, 10'd2);
    for (int k = 0; k < 6; k++) begin
      send_byte(stream[k], ok);
      check("byte_accepted", ok, 1'b1);
    end
    reset = 1'b1;
    @(negedge clock);
    check("midload_reset_outputs",
          {byte_ready, address, i_ram_input, flag_write_i_ram, busy, done, error},
          '0);
    reset = 1'b0;
    repeat (TO + 4) @(negedge clock);
    check("midload_idle_after_reset", busy, 1'b0);

    // A normal load after the aborted one.
    fill_random(12);
    run_load(10'd512, 10'd3, model_sum(12), -1);

    repeat (5) @(negedge clock);
    check("writes_outstanding", exp_q.size(), 0);
    check("dones_outstanding", exp_done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
